// File: rtl/if_id_stage_if.sv
// -----------------------------------------------------------------------------
// if_id_stage_if
// Purpose : bundles the fetch-stage control inputs, the instruction-memory
//           read port and the IF/ID pipeline register outputs of if_id_stage.
// Signals : stall, flush, jump, jr, branch_taken   - hazard / redirect controls
//           jr_target[31:0], branch_offset[31:0]   - redirect operands
//           imem_data[31:0]                        - instruction read at pc
//           pc[31:0]                               - fetch address
//           id_instr[31:0], id_pc4[31:0], id_valid - IF/ID register
//           opc[5:0], func[5:0]                    - decode fields of id_instr
//           stall_cnt[15:0], flush_cnt[15:0]       - only with IF_ID_PERF_CNT_EN
// Modports: master - surrounding pipeline (drives controls, receives outputs)
//           slave  - the if_id_stage block itself
// Config  : IF_ID_PERF_CNT_EN adds the two performance counters.
// -----------------------------------------------------------------------------
interface if_id_stage_if;
   logic        stall;
   logic        flush;
   logic        jump;
   logic        jr;
   logic        branch_taken;
   logic [31:0] jr_target;
   logic [31:0] branch_offset;
   logic [31:0] imem_data;
   logic [31:0] pc;
   logic [31:0] id_instr;
   logic [31:0] id_pc4;
   logic [5:0]  opc;
   logic [5:0]  func;
   logic        id_valid;
`ifdef IF_ID_PERF_CNT_EN
   logic [15:0] stall_cnt;
   logic [15:0] flush_cnt;

   modport master (
      output stall, flush, jump, jr, branch_taken,
      output jr_target, branch_offset, imem_data,
      input  pc, id_instr, id_pc4, opc, func, id_valid,
      input  stall_cnt, flush_cnt
   );

   modport slave (
      input  stall, flush, jump, jr, branch_taken,
      input  jr_target, branch_offset, imem_data,
      output pc, id_instr, id_pc4, opc, func, id_valid,
      output stall_cnt, flush_cnt
   );
`else
   modport master (
      output stall, flush, jump, jr, branch_taken,
      output jr_target, branch_offset, imem_data,
      input  pc, id_instr, id_pc4, opc, func, id_valid
   );

   modport slave (
      input  stall, flush, jump, jr, branch_taken,
      input  jr_target, branch_offset, imem_data,
      output pc, id_instr, id_pc4, opc, func, id_valid
   );
`endif
endinterface

// File: rtl/if_id_stage.sv
// -----------------------------------------------------------------------------
// if_id_stage
// Purpose : program counter, next-PC selection and the IF/ID pipeline register
//           of a classic 5-stage MIPS-style pipeline.
// Ports   : clk  - rising-edge clock
//           rst  - asynchronous active-high reset
//           bus  - if_id_stage_if.slave (controls, imem read, IF/ID outputs)
// Config  : IF_ID_PERF_CNT_EN - when defined, adds saturating 16-bit stall_cnt
//           and flush_cnt counters on the interface; default build omits them.
// -----------------------------------------------------------------------------
module if_id_stage (
   input logic         clk,
   input logic         rst,
   if_id_stage_if.slave bus
);

   logic [31:0] pc_q, pc_d;
   logic [31:0] id_instr_q, id_instr_d;
   logic [31:0] id_pc4_q, id_pc4_d;
   logic        id_valid_q, id_valid_d;

   logic [31:0] pc_plus4_s;
   logic [31:0] jump_target_s;
   logic [31:0] branch_target_s;
   logic [31:0] next_pc_s;

   // Sequential address wraps naturally through 32-bit modular addition.
   assign pc_plus4_s      = pc_q + 32'd4;
   // Pseudo-direct target takes its upper nibble from the decode-stage PC+4.
   assign jump_target_s   = {id_pc4_q[31:28], id_instr_q[25:0], 2'b00};
   // Word offset converted to a byte offset; overflow wraps modulo 2^32.
   assign branch_target_s = id_pc4_q + (bus.branch_offset << 5'd2);

   // Next-PC priority mux: jr, then jump, then taken branch, then sequential.
   always_comb begin
      next_pc_s = pc_plus4_s;
      if (bus.jr) begin
         next_pc_s = bus.jr_target;
      end else if (bus.jump) begin
         next_pc_s = jump_target_s;
      end else if (bus.branch_taken) begin
         next_pc_s = branch_target_s;
      end else begin
         next_pc_s = pc_plus4_s;
      end
   end

   // Next-state for PC and IF/ID: stall holds everything, flush injects a NOP.
   always_comb begin
      pc_d       = pc_q;
      id_instr_d = id_instr_q;
      id_pc4_d   = id_pc4_q;
      id_valid_d = id_valid_q;
      if (!bus.stall) begin
         pc_d     = next_pc_s;
         id_pc4_d = pc_plus4_s;
         if (bus.flush) begin
            id_instr_d = 32'h0000_0000;
            id_valid_d = 1'b0;
         end else begin
            id_instr_d = bus.imem_data;
            id_valid_d = 1'b1;
         end
      end else begin
         pc_d       = pc_q;
         id_instr_d = id_instr_q;
         id_pc4_d   = id_pc4_q;
         id_valid_d = id_valid_q;
      end
   end

   // PC and IF/ID register state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q       <= 32'h0000_0000;
         id_instr_q <= 32'h0000_0000;
         id_pc4_q   <= 32'h0000_0000;
         id_valid_q <= 1'b0;
      end else begin
         pc_q       <= pc_d;
         id_instr_q <= id_instr_d;
         id_pc4_q   <= id_pc4_d;
         id_valid_q <= id_valid_d;
      end
   end

   assign bus.pc       = pc_q;
   assign bus.id_instr = id_instr_q;
   assign bus.id_pc4   = id_pc4_q;
   assign bus.id_valid = id_valid_q;
   // Decode fields are plain slices so the control unit sees them with no delay.
   assign bus.opc      = id_instr_q[31:26];
   assign bus.func     = id_instr_q[5:0];

`ifdef IF_ID_PERF_CNT_EN
   logic [15:0] stall_cnt_q, stall_cnt_d;
   logic [15:0] flush_cnt_q, flush_cnt_d;

   // Saturating counters: stalled edges, and unstalled edges that squash.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (bus.stall && (stall_cnt_q != 16'hFFFF)) begin
         stall_cnt_d = stall_cnt_q + 16'd1;
      end else begin
         stall_cnt_d = stall_cnt_q;
      end
      if (!bus.stall && bus.flush && (flush_cnt_q != 16'hFFFF)) begin
         flush_cnt_d = flush_cnt_q + 16'd1;
      end else begin
         flush_cnt_d = flush_cnt_q;
      end
   end

   // Counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt_q <= 16'h0000;
         flush_cnt_q <= 16'h0000;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign bus.stall_cnt = stall_cnt_q;
   assign bus.flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// -----------------------------------------------------------------------------
// tb_if_id_stage
// Directed bench for if_id_stage: a linear sequence of steps, each followed by
// immediate assertions against hand-computed values.
// -----------------------------------------------------------------------------
module tb_if_id_stage;

   logic clk;
   logic rst;
   int   test_cnt;
   int   fail_cnt;

   if_id_stage_if bus_if ();

   if_id_stage dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      test_cnt++;
      assert (obs === exp) else begin
         fail_cnt++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and settle just after it.
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_regs(input string tag, input logic [31:0] e_pc,
                           input logic [31:0] e_instr, input logic [31:0] e_pc4,
                           input logic e_valid);
      chk({tag, ".pc"},       bus_if.pc,       e_pc);
      chk({tag, ".id_instr"}, bus_if.id_instr, e_instr);
      chk({tag, ".id_pc4"},   bus_if.id_pc4,   e_pc4);
      chk({tag, ".id_valid"}, {31'd0, bus_if.id_valid}, {31'd0, e_valid});
   endtask

   initial begin
      test_cnt = 0;
      fail_cnt = 0;
      rst                  = 1'b1;
      bus_if.stall         = 1'b0;
      bus_if.flush         = 1'b0;
      bus_if.jump          = 1'b0;
      bus_if.jr            = 1'b0;
      bus_if.branch_taken  = 1'b0;
      bus_if.jr_target     = 32'h0000_0000;
      bus_if.branch_offset = 32'h0000_0000;
      bus_if.imem_data     = 32'h2008_0005;

      // Reset state, including an edge that occurs while reset is held.
      #12;
      chk_regs("reset", 32'h0, 32'h0, 32'h0, 1'b0);
      chk("reset.opc",  {26'd0, bus_if.opc},  32'h0);
      chk("reset.func", {26'd0, bus_if.func}, 32'h0);
`ifdef IF_ID_PERF_CNT_EN
      chk("reset.stall_cnt", {16'd0, bus_if.stall_cnt}, 32'h0);
      chk("reset.flush_cnt", {16'd0, bus_if.flush_cnt}, 32'h0);
`endif
      rst = 1'b0;
      chk("first_fetch.pc", bus_if.pc, 32'h0);

      // Sequential fetch with a constant instruction.
      tick;
      chk_regs("seq1", 32'h4, 32'h2008_0005, 32'h4, 1'b1);
      chk("seq1.opc",  {26'd0, bus_if.opc},  32'h08);
      chk("seq1.func", {26'd0, bus_if.func}, 32'h05);
      tick;
      chk("seq2.pc", bus_if.pc, 32'h8);
      tick;
      // id_pc4 is PC+4 of the instruction fetched from address 8.
      chk_regs("seq3", 32'hC, 32'h2008_0005, 32'hC, 1'b1);

      // Walk on to pc=0x40 (13 more sequential edges).
      for (int i = 0; i < 13; i++) tick;
      chk_regs("seq40", 32'h40, 32'h2008_0005, 32'h40, 1'b1);

      // Taken branch with negative word offset, squashing the fetched slot.
      bus_if.branch_taken  = 1'b1;
      bus_if.flush         = 1'b1;
      bus_if.branch_offset = 32'hFFFF_FFFC;
      tick;
      chk_regs("branch", 32'h30, 32'h0, 32'h44, 1'b0);
      bus_if.branch_taken = 1'b0;
      bus_if.flush        = 1'b0;

      // Redirect without flush still loads the fetched instruction.
      bus_if.jr        = 1'b1;
      bus_if.jr_target = 32'h1000_0004;
      bus_if.imem_data = 32'h1234_5678;
      tick;
      chk_regs("jr_noflush", 32'h1000_0004, 32'h1234_5678, 32'h34, 1'b1);
      bus_if.jr        = 1'b0;

      bus_if.imem_data = 32'h0800_0100;
      tick;
      chk_regs("pre_jump", 32'h1000_0008, 32'h0800_0100, 32'h1000_0008, 1'b1);
      chk("pre_jump.opc", {26'd0, bus_if.opc}, 32'h02);

      // Pseudo-direct jump.
      bus_if.jump  = 1'b1;
      bus_if.flush = 1'b1;
      tick;
      chk_regs("jump", 32'h1000_0400, 32'h0, 32'h1000_000C, 1'b0);
      bus_if.jump  = 1'b0;
      bus_if.flush = 1'b0;

      bus_if.imem_data = 32'hAABB_CCDD;
      tick;
      chk_regs("after_jump", 32'h1000_0404, 32'hAABB_CCDD, 32'h1000_0404, 1'b1);
      chk("after_jump.func", {26'd0, bus_if.func}, 32'h1D);

      // Stall beats flush and every redirect.
      bus_if.jr        = 1'b1;
      bus_if.jump      = 1'b1;
      bus_if.flush     = 1'b1;
      bus_if.jr_target = 32'h0000_0200;
      bus_if.stall     = 1'b1;
      tick;
      chk_regs("stall_hold", 32'h1000_0404, 32'hAABB_CCDD, 32'h1000_0404, 1'b1);

      // Same redirect unstalled: jr wins over jump.
      bus_if.stall = 1'b0;
      tick;
      chk_regs("jr_over_jump", 32'h200, 32'h0, 32'h1000_0408, 1'b0);
      bus_if.jump  = 1'b0;
      bus_if.flush = 1'b0;

      // PC wrap from the top of the address space.
      bus_if.jr_target = 32'hFFFF_FFFC;
      tick;
      chk_regs("to_top", 32'hFFFF_FFFC, 32'hAABB_CCDD, 32'h204, 1'b1);
      bus_if.jr        = 1'b0;
      bus_if.imem_data = 32'h0123_4567;
      tick;
      chk_regs("wrap", 32'h0, 32'h0123_4567, 32'h0, 1'b1);

      // Asynchronous reset between edges, asserted mid-stall with a redirect.
      tick;
      bus_if.stall = 1'b1;
      bus_if.jump  = 1'b1;
      #3;
      rst = 1'b1;
      #1;
      chk_regs("async_rst", 32'h0, 32'h0, 32'h0, 1'b0);
      chk("async_rst.opc", {26'd0, bus_if.opc}, 32'h0);
      rst          = 1'b0;
      bus_if.stall = 1'b0;
      bus_if.jump  = 1'b0;
      tick;
      chk_regs("post_rst", 32'h4, 32'h0123_4567, 32'h4, 1'b1);

`ifdef IF_ID_PERF_CNT_EN
      bus_if.stall = 1'b1;
      for (int i = 0; i < 5; i++) tick;
      chk("cnt.stall5", {16'd0, bus_if.stall_cnt}, 32'd5);
      chk("cnt.stall_pc", bus_if.pc, 32'h4);
      bus_if.stall = 1'b0;
      bus_if.flush = 1'b1;
      for (int i = 0; i < 2; i++) tick;
      chk("cnt.flush2", {16'd0, bus_if.flush_cnt}, 32'd2);
      chk("cnt.stall_kept", {16'd0, bus_if.stall_cnt}, 32'd5);
      bus_if.flush = 1'b0;
      bus_if.stall = 1'b1;
      for (int i = 0; i < 70000; i++) tick;
      chk("cnt.stall_sat", {16'd0, bus_if.stall_cnt}, 32'h0000_FFFF);
      chk("cnt.flush_kept", {16'd0, bus_if.flush_cnt}, 32'd2);
      bus_if.stall = 1'b0;
`endif

      $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
      $finish;
   end

endmodule
